// File: rtl/mandelbrot_pkg.sv
// Shared definitions for the Mandelbrot pixel pipeline.
// Used by the iteration controller and the coordinate generator.
//   state_t    : controller state encoding (binary, 2 bits)
//   DEF_WIDTH  : default data width, signed 2.(WIDTH-2) fixed point
//   DEF_ITER_W : default width of iteration limit / count
//   ONE        : fixed-point 1.0 at DEF_WIDTH
package mandelbrot_pkg;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_ITER_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [DEF_WIDTH-1:0] ONE = DEF_WIDTH'(32'd1 << (DEF_WIDTH - 2));

endpackage

// File: rtl/mandelbrot_iter_counter.sv
// Iteration counter for the Mandelbrot controller.
// Latches the per-point limit on clear, counts completed z updates, and
// flags when the count has reached the latched limit.
//   clk, rst  : clock, synchronous active-high reset
//   clear     : zero the count and latch limit (point accept)
//   inc       : advance the count by one (z update)
//   limit     : iteration limit for the incoming point
//   count     : current iteration count
//   at_limit  : count equals the latched limit
module mandelbrot_iter_counter
  import mandelbrot_pkg::*;
#(
  parameter int ITER_W = DEF_ITER_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              inc,
  input  logic [ITER_W-1:0] limit,
  output logic [ITER_W-1:0] count,
  output logic              at_limit
);

  logic [ITER_W-1:0] iter_r;
  logic [ITER_W-1:0] limit_r;

  // Count and limit registers; clear has priority over inc.
  always_ff @(posedge clk) begin
    if (rst) begin
      iter_r  <= {ITER_W{1'b0}};
      limit_r <= {ITER_W{1'b0}};
    end else if (clear) begin
      iter_r  <= {ITER_W{1'b0}};
      limit_r <= limit;
    end else if (inc) begin
      // The controller stops before iter passes the limit, so this never wraps.
      iter_r  <= iter_r + ITER_W'(1);
    end else begin
      iter_r  <= iter_r;
      limit_r <= limit_r;
    end
  end

  assign count    = iter_r;
  assign at_limit = (iter_r == limit_r);

endmodule

// File: rtl/mandelbrot_iter_ctrl.sv
// Mandelbrot iteration controller.
// Accepts a point c and an iteration limit, steps z <- z^2 + c through an
// external combinational ALU one step per clock, and returns the escape
// iteration count plus an escaped flag.
//   in_valid/in_ready          : point request handshake (in_cr, in_ci, in_max_iter)
//   alu_cr/ci/zr/zi            : registered operands driven to the ALU
//   alu_zr_next/zi_next/size   : ALU results and escape flag for current z
//   out_valid/out_ready        : result handshake (out_iter, out_escaped)
//   busy                       : high while a point is running or its result is pending
module mandelbrot_iter_ctrl
  import mandelbrot_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int ITER_W = DEF_ITER_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_cr,
  input  logic [WIDTH-1:0]  in_ci,
  input  logic [ITER_W-1:0] in_max_iter,
  output logic [WIDTH-1:0]  alu_cr,
  output logic [WIDTH-1:0]  alu_ci,
  output logic [WIDTH-1:0]  alu_zr,
  output logic [WIDTH-1:0]  alu_zi,
  input  logic [WIDTH-1:0]  alu_zr_next,
  input  logic [WIDTH-1:0]  alu_zi_next,
  input  logic              alu_size,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ITER_W-1:0] out_iter,
  output logic              out_escaped,
  output logic              busy
);

  state_t            state_r;
  state_t            state_next_s;
  logic              accept_s;
  logic              step_s;
  logic              finish_s;
  logic              escaped_s;
  logic [WIDTH-1:0]  cr_r;
  logic [WIDTH-1:0]  ci_r;
  logic [WIDTH-1:0]  zr_r;
  logic [WIDTH-1:0]  zi_r;
  logic [ITER_W-1:0] iter_s;
  logic              at_limit_s;
  logic [ITER_W-1:0] out_iter_r;
  logic              out_escaped_r;
  logic              in_ready_r;
  logic              out_valid_r;
  logic              busy_r;

  mandelbrot_iter_counter #(
    .ITER_W (ITER_W)
  ) u_counter (
    .clk      (clk),
    .rst      (rst),
    .clear    (accept_s),
    .inc      (step_s),
    .limit    (in_max_iter),
    .count    (iter_s),
    .at_limit (at_limit_s)
  );

  // Next-state and control strobes; escape takes priority over the limit.
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    step_s       = 1'b0;
    finish_s     = 1'b0;
    escaped_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          accept_s     = 1'b1;
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (alu_size) begin
          finish_s     = 1'b1;
          escaped_s    = 1'b1;
          state_next_s = ST_DONE;
        end else if (at_limit_s) begin
          finish_s     = 1'b1;
          escaped_s    = 1'b0;
          state_next_s = ST_DONE;
        end else begin
          step_s       = 1'b1;
          state_next_s = ST_RUN;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_DONE;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State register; handshake flags are registered from the next state so
  // they always agree with state_r.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      in_ready_r  <= (state_next_s == ST_IDLE);
      out_valid_r <= (state_next_s == ST_DONE);
      busy_r      <= (state_next_s != ST_IDLE);
    end
  end

  // Point and z registers; ALU results are stored verbatim.
  always_ff @(posedge clk) begin
    if (rst) begin
      cr_r <= {WIDTH{1'b0}};
      ci_r <= {WIDTH{1'b0}};
      zr_r <= {WIDTH{1'b0}};
      zi_r <= {WIDTH{1'b0}};
    end else if (accept_s) begin
      cr_r <= in_cr;
      ci_r <= in_ci;
      zr_r <= {WIDTH{1'b0}};
      zi_r <= {WIDTH{1'b0}};
    end else if (step_s) begin
      zr_r <= alu_zr_next;
      zi_r <= alu_zi_next;
    end else begin
      zr_r <= zr_r;
      zi_r <= zi_r;
    end
  end

  // Result registers, captured on the terminating RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_iter_r    <= {ITER_W{1'b0}};
      out_escaped_r <= 1'b0;
    end else if (finish_s) begin
      out_iter_r    <= iter_s;
      out_escaped_r <= escaped_s;
    end else begin
      out_iter_r    <= out_iter_r;
      out_escaped_r <= out_escaped_r;
    end
  end

  assign in_ready    = in_ready_r;
  assign out_valid   = out_valid_r;
  assign busy        = busy_r;
  assign out_iter    = out_iter_r;
  assign out_escaped = out_escaped_r;
  assign alu_cr      = cr_r;
  assign alu_ci      = ci_r;
  assign alu_zr      = zr_r;
  assign alu_zi      = zi_r;

endmodule

// File: tb/tb_mandelbrot_iter_ctrl.sv
// Self-checking bench for mandelbrot_iter_ctrl.
// Provides a behavioural Mandelbrot ALU (real arithmetic, or forced escape
// behaviour) and compares each point against an iterate-until-done model.
module tb_mandelbrot_iter_ctrl;

  localparam int WIDTH  = 8;
  localparam int ITER_W = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_cr;
  logic [WIDTH-1:0]  in_ci;
  logic [ITER_W-1:0] in_max_iter;
  logic [WIDTH-1:0]  alu_cr;
  logic [WIDTH-1:0]  alu_ci;
  logic [WIDTH-1:0]  alu_zr;
  logic [WIDTH-1:0]  alu_zi;
  logic [WIDTH-1:0]  alu_zr_next;
  logic [WIDTH-1:0]  alu_zi_next;
  logic              alu_size;
  logic              out_valid;
  logic              out_ready;
  logic [ITER_W-1:0] out_iter;
  logic              out_escaped;
  logic              busy;

  int n_cmp = 0;
  int n_bad = 0;
  // ALU behaviour: 0 = real escape test, 1 = never escape, 2 = escape at run index esc_at
  int alu_mode = 0;
  int esc_at   = -1;
  int run_idx  = -100;

  mandelbrot_iter_ctrl #(
    .WIDTH  (WIDTH),
    .ITER_W (ITER_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_cr       (in_cr),
    .in_ci       (in_ci),
    .in_max_iter (in_max_iter),
    .alu_cr      (alu_cr),
    .alu_ci      (alu_ci),
    .alu_zr      (alu_zr),
    .alu_zi      (alu_zi),
    .alu_zr_next (alu_zr_next),
    .alu_zi_next (alu_zi_next),
    .alu_size    (alu_size),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_iter    (out_iter),
    .out_escaped (out_escaped),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  function automatic int wrap8(input int v);
    logic signed [7:0] b;
    b = v[7:0];
    return int'(b);
  endfunction

  // z^2 + c in signed 2.6 fixed point, wrapped to 8 bits.
  function automatic int next_r(input int zr, input int zi, input int cr);
    return wrap8(((zr * zr - zi * zi) >>> 6) + cr);
  endfunction

  function automatic int next_i(input int zr, input int zi, input int ci);
    return wrap8(((2 * zr * zi) >>> 6) + ci);
  endfunction

  // |z|^2 >= 4.0 ; squares are in 4.12 so 4.0 is 16384.
  function automatic bit real_esc(input int zr, input int zi);
    return (zr * zr + zi * zi) >= 16384;
  endfunction

  // Behavioural external ALU.
  always_comb begin
    alu_zr_next = 8'(next_r(int'($signed(alu_zr)), int'($signed(alu_zi)), int'($signed(alu_cr))));
    alu_zi_next = 8'(next_i(int'($signed(alu_zr)), int'($signed(alu_zi)), int'($signed(alu_ci))));
    if (alu_mode == 0) begin
      alu_size = real_esc(int'($signed(alu_zr)), int'($signed(alu_zi)));
    end else if (alu_mode == 1) begin
      alu_size = 1'b0;
    end else begin
      alu_size = (run_idx == esc_at);
    end
  end

  // Reference: iterate the escape rule directly on integers.
  function automatic void model(input int cr, input int ci, input int mx, input int mode,
                                input int eat, output int k, output int e,
                                output int zr, output int zi);
    int nr;
    bit s;
    zr = 0; zi = 0; k = 0; e = 0;
    for (int i = 0; i <= mx; i++) begin
      if (mode == 0) s = real_esc(zr, zi);
      else if (mode == 1) s = 1'b0;
      else s = (i == eat);
      if (s) begin k = i; e = 1; return; end
      if (i == mx) begin k = i; e = 0; return; end
      nr = next_r(zr, zi, cr);
      zi = next_i(zr, zi, ci);
      zr = nr;
    end
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full point: accept, run to completion, hold under backpressure, release.
  task automatic run_point(input int cr, input int ci, input int mx, input int mode,
                           input int eat, input int bp, input string tag);
    int k, e, zr, zi, lat, w;
    alu_mode = mode;
    esc_at   = eat;
    model(cr, ci, mx, mode, eat, k, e, zr, zi);
    w = 0;
    while (!in_ready && w < 50) begin tick(); w++; end
    check({tag, ".in_ready"}, int'(in_ready), 1);
    in_cr       = 8'(cr);
    in_ci       = 8'(ci);
    in_max_iter = 6'(mx);
    in_valid    = 1'b1;
    tick();
    in_valid    = 1'b0;
    run_idx     = 0;
    // Inputs change after accept and must be ignored.
    in_cr       = 8'($urandom);
    in_ci       = 8'($urandom);
    in_max_iter = 6'($urandom);
    lat = 0;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
      run_idx++;
    end
    check({tag, ".latency"}, lat, k + 1);
    check({tag, ".out_iter"}, int'(out_iter), k);
    check({tag, ".out_escaped"}, int'(out_escaped), e);
    check({tag, ".zr"}, int'($signed(alu_zr)), zr);
    check({tag, ".zi"}, int'($signed(alu_zi)), zi);
    check({tag, ".cr"}, int'($signed(alu_cr)), wrap8(cr));
    check({tag, ".done_in_ready"}, int'(in_ready), 0);
    check({tag, ".done_busy"}, int'(busy), 1);
    for (int i = 0; i < bp; i++) begin
      tick();
      check({tag, ".hold_valid"}, int'(out_valid), 1);
      check({tag, ".hold_iter"}, int'(out_iter), k);
      check({tag, ".hold_esc"}, int'(out_escaped), e);
      check({tag, ".hold_in_ready"}, int'(in_ready), 0);
      check({tag, ".hold_zr"}, int'($signed(alu_zr)), zr);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    run_idx   = -100;
    check({tag, ".rel_valid"}, int'(out_valid), 0);
    check({tag, ".rel_in_ready"}, int'(in_ready), 1);
    check({tag, ".rel_busy"}, int'(busy), 0);
  endtask

  initial begin
    int cr, ci, mx, md, ea;
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_cr       = 8'd0;
    in_ci       = 8'd0;
    in_max_iter = 6'd0;
    out_ready   = 1'b0;
    tick();
    tick();
    check("reset.in_ready", int'(in_ready), 1);
    check("reset.out_valid", int'(out_valid), 0);
    check("reset.busy", int'(busy), 0);
    check("reset.out_iter", int'(out_iter), 0);
    check("reset.zr", int'(alu_zr), 0);
    rst = 1'b0;
    tick();

    // Limit reached, no escape
    run_point(5, -3, 10, 1, -1, 0, "limit10");
    // Forced escape at iteration 4 with backpressure
    run_point(7, 9, 20, 2, 4, 5, "esc4");
    // Zero limit with the real ALU
    run_point(0, 0, 0, 0, -1, 1, "max0");
    // Largest limit, no wrap
    run_point(3, 1, 63, 1, -1, 0, "max63");
    // Real ALU at the origin never escapes
    run_point(0, 0, 15, 0, -1, 0, "origin15");
    // c = 0.5: z goes 0, 32, 48, 68
    run_point(32, 0, 3, 0, -1, 0, "half");
    // Random escape at the limit boundary itself
    run_point(1, 2, 6, 2, 6, 0, "esc_at_lim");

    // Reset while running at iter 3
    alu_mode    = 1;
    in_cr       = 8'd40;
    in_ci       = 8'd20;
    in_max_iter = 6'd20;
    in_valid    = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstrun.in_ready", int'(in_ready), 1);
    check("rstrun.out_valid", int'(out_valid), 0);
    check("rstrun.busy", int'(busy), 0);
    check("rstrun.zr", int'(alu_zr), 0);
    check("rstrun.zi", int'(alu_zi), 0);
    check("rstrun.cr", int'(alu_cr), 0);
    tick();
    check("rstrun.idle_hold", int'(out_valid), 0);

    // Randomized points against the reference model
    for (int n = 0; n < 12; n++) begin
      cr = wrap8(int'($urandom));
      ci = wrap8(int'($urandom));
      mx = int'($urandom_range(0, 63));
      md = (n % 4 == 3) ? 2 : 0;
      ea = int'($urandom_range(0, 63));
      run_point(cr, ci, mx, md, ea, int'($urandom_range(0, 3)), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mandelbrot_iter_ctrl.md
Name: mandelbrot_iter_ctrl

Overview:
Sequences the combinational Mandelbrot step ALU for one pixel at a time. Accepts a point c and an iteration limit over a valid/ready handshake, then iterates z <- z^2 + c through the external ALU ports, one step per clock. Returns the escape iteration count and an escaped flag over a second valid/ready handshake. Sits between the pixel/coordinate generator and the colour mapper; the ALU is instantiated beside it at the next level up.

Parameters:
WIDTH, 8, data width of cr/ci/zr/zi in signed 2.(WIDTH-2) fixed point
ITER_W, 6, width of iteration limit and count

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  point request valid
in_ready  out  1  controller can accept a point
in_cr  in  WIDTH  real part of c
in_ci  in  WIDTH  imaginary part of c
in_max_iter  in  ITER_W  iteration limit for this point
alu_cr  out  WIDTH  latched cr to ALU
alu_ci  out  WIDTH  latched ci to ALU
alu_zr  out  WIDTH  current zr register to ALU
alu_zi  out  WIDTH  current zi register to ALU
alu_zr_next  in  WIDTH  ALU out_zr
alu_zi_next  in  WIDTH  ALU out_zi
alu_size  in  1  ALU escape flag for current z
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_iter  out  ITER_W  iteration count at termination
out_escaped  out  1  1 = escaped, 0 = limit reached
busy  out  1  high in RUN or DONE

Behaviour:
- Reset (synchronous, active-high): state IDLE; zr, zi, cr, ci, max_iter, iter, out_iter, out_escaped all 0; in_ready=1, out_valid=0, busy=0. Reset mid-RUN or mid-DONE discards the point and any pending result.
- States: IDLE, RUN, DONE. Encoding: binary, 2 bits.
- IDLE: in_ready=1. On in_valid & in_ready: latch cr, ci, max_iter; set zr=zi=0, iter=0; go RUN.
- RUN: in_ready=0. ALU sees the latched c and current z combinationally. Each cycle, evaluated in priority order:
  - alu_size=1: out_iter<=iter, out_escaped<=1, go DONE.
  - else iter==max_iter: out_iter<=iter, out_escaped<=0, go DONE.
  - else zr<=alu_zr_next, zi<=alu_zi_next, iter<=iter+1.
- DONE: out_valid=1; out_iter and out_escaped are stable. On out_valid & out_ready go IDLE. in_ready stays 0 until IDLE; there is no result/request overlap.
- Latency: accept at edge T; first RUN cycle has iter=0. A point terminating with count k has out_valid high from cycle T+2+k. Minimum handshake-to-handshake period is k+3 cycles.
- max_iter=0: terminates in the first RUN cycle with out_iter=0. out_escaped=alu_size for z=0, which is 0 for the real ALU.
- iter never exceeds max_iter, so no counter wrap. Maximum limit is 2^ITER_W-1.
- z arithmetic wrap and overflow are the ALU's concern. The controller stores alu_*_next verbatim.
- alu_cr/alu_ci/alu_zr/alu_zi are driven directly from registers, including in IDLE and DONE. The ALU is purely combinational with no enable.
- in_* inputs are ignored outside the IDLE accept cycle. out_ready is ignored outside DONE.

Decomposition:
- Shared package (mandelbrot_pkg): state localparams ST_IDLE/ST_RUN/ST_DONE, default WIDTH and ITER_W, fixed-point constant ONE = 1<<(WIDTH-2). The package is shared with the coordinate generator.
- One sub-module is natural: mandelbrot_iter_counter (clear, increment, equality compare against the latched limit).
- The ALU itself stays outside the controller so a top-level can time-share or replace it.

Test Plan:
- Reset mid-RUN: accept point, rst high for 1 cycle at RUN iter=3 -> next cycle IDLE, in_ready=1, out_valid=0, zr=zi=0.
- Limit reached: stub alu_size=0, in_max_iter=10, accept at T -> out_valid at T+12, out_iter=10, out_escaped=0, exactly 10 z updates observed.
- Escape: stub raises alu_size while iter=4, max_iter=20 -> out_valid at T+6, out_iter=4, out_escaped=1; z registers frozen after 4 updates.
- Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid, out_iter and out_escaped held stable, in_ready=0; on out_ready=1 -> IDLE next cycle, in_ready=1.
- Edge limit: in_max_iter=0 -> out_iter=0, out_escaped=0 at T+2. With in_max_iter=63 (ITER_W=6) and no escape -> out_iter=63, no wrap.
- Real ALU, WIDTH=8: cr=ci=0, max_iter=15 -> out_iter=15, out_escaped=0. Data check: with cr=32 (0.5), ci=0 the z sequence is 0, 32, 48, 68, ... matching an ALU reference model.
